// File: rtl/dom_shared_mul_gf2n_pipe_if.sv
// Handshake and share bus for the pipelined DOM GF(2^N) multiplier.
interface dom_shared_mul_gf2n_pipe_if #(
  parameter int unsigned N      = 4,
  parameter int unsigned SHARES = 2
);
  localparam int unsigned NumPairs = SHARES * (SHARES - 1) / 2;

  logic [N*SHARES-1:0]   XxD;
  logic [N*SHARES-1:0]   YxD;
  logic [N*NumPairs-1:0] ZxD;
  logic                  RndValidxS;
  logic                  RndAckxS;
  logic                  InValidxS;
  logic                  InReadyxS;
  logic                  OutValidxS;
  logic                  OutReadyxS;
  logic [N*SHARES-1:0]   QxD;

  modport master (
    output XxD, YxD, ZxD, RndValidxS, InValidxS, OutReadyxS,
    input  RndAckxS, InReadyxS, OutValidxS, QxD
  );

  modport slave (
    input  XxD, YxD, ZxD, RndValidxS, InValidxS, OutReadyxS,
    output RndAckxS, InReadyxS, OutValidxS, QxD
  );
endinterface

// File: rtl/dom_shared_mul_gf2n_pipe.sv
// Domain-oriented-masking multiplier over GF(2^N), arbitrary share count,
// with valid/ready flow control, randomness handshake, optional output
// register and synchronous flush.
module dom_shared_mul_gf2n_pipe #(
  parameter int unsigned N       = 4,
  parameter logic [N:0]  POLY    = 5'h13,
  parameter int unsigned SHARES  = 2,
  parameter bit          OUT_REG = 1'b1
) (
  input logic ClkxCI,
  input logic RstxBI,
  input logic FlushxSI,
  dom_shared_mul_gf2n_pipe_if.slave bus
);

  localparam int unsigned NumPairs = SHARES * (SHARES - 1) / 2;
  localparam int unsigned DataW    = N * SHARES;

  typedef logic [N-1:0] elem_t;

  // Shift-and-add GF(2^N) product, reducing after every shift.
  function automatic elem_t gfMul(input elem_t a, input elem_t b);
    elem_t acc;
    elem_t sh;
    elem_t bb;
    acc = '0;
    sh  = a;
    bb  = b;
    for (int unsigned i = 0; i < N; i++) begin
      if (bb[0]) acc = acc ^ sh;
      bb = bb >> 1;
      sh = sh[N-1] ? ((sh << 1) ^ POLY[N-1:0]) : (sh << 1);
    end
    return acc;
  endfunction

  elem_t xSh [SHARES];
  elem_t ySh [SHARES];
  elem_t zPair [NumPairs];

  elem_t innerD [SHARES];
  elem_t crossLoD [NumPairs];
  elem_t crossHiD [NumPairs];

  elem_t innerQ [SHARES];
  elem_t crossLoQ [NumPairs];
  elem_t crossHiQ [NumPairs];
  logic  v1Q;

  elem_t             sumD [SHARES];
  logic [DataW-1:0]  sumFlat;

  logic advance1;
  logic inReady;
  logic accept;

  // Unpack the flat share and randomness buses.
  always_comb begin
    for (int unsigned i = 0; i < SHARES; i++) begin
      xSh[i] = bus.XxD[i*N +: N];
      ySh[i] = bus.YxD[i*N +: N];
    end
    for (int unsigned k = 0; k < NumPairs; k++) begin
      zPair[k] = bus.ZxD[k*N +: N];
    end
  end

  // Per-domain inner products and resharing-masked cross products.
  always_comb begin
    int unsigned k;
    k = 0;
    for (int unsigned i = 0; i < SHARES; i++) begin
      innerD[i] = gfMul(xSh[i], ySh[i]);
    end
    for (int unsigned p = 0; p < NumPairs; p++) begin
      crossLoD[p] = '0;
      crossHiD[p] = '0;
    end
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = i + 1; j < SHARES; j++) begin
        crossLoD[k] = gfMul(xSh[i], ySh[j]) ^ zPair[k];
        crossHiD[k] = gfMul(xSh[j], ySh[i]) ^ zPair[k];
        k = k + 1;
      end
    end
  end

  assign inReady      = RstxBI & ~FlushxSI & (~v1Q | advance1);
  assign accept       = bus.InValidxS & bus.RndValidxS & inReady;
  assign bus.InReadyxS = inReady;
  assign bus.RndAckxS  = accept;

  // Stage 1: every term is registered before any cross-domain summation.
  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      v1Q <= 1'b0;
      for (int unsigned i = 0; i < SHARES; i++) innerQ[i] <= '0;
      for (int unsigned p = 0; p < NumPairs; p++) begin
        crossLoQ[p] <= '0;
        crossHiQ[p] <= '0;
      end
    end else if (FlushxSI) begin
      v1Q <= 1'b0;
      for (int unsigned i = 0; i < SHARES; i++) innerQ[i] <= '0;
      for (int unsigned p = 0; p < NumPairs; p++) begin
        crossLoQ[p] <= '0;
        crossHiQ[p] <= '0;
      end
    end else begin
      if (accept) begin
        v1Q <= 1'b1;
        for (int unsigned i = 0; i < SHARES; i++) innerQ[i] <= innerD[i];
        for (int unsigned p = 0; p < NumPairs; p++) begin
          crossLoQ[p] <= crossLoD[p];
          crossHiQ[p] <= crossHiD[p];
        end
      end else if (advance1) begin
        v1Q <= 1'b0;
      end
    end
  end

  // Compress each domain from registered terms only.
  always_comb begin
    int unsigned k;
    k = 0;
    for (int unsigned i = 0; i < SHARES; i++) sumD[i] = innerQ[i];
    for (int unsigned i = 0; i < SHARES; i++) begin
      for (int unsigned j = i + 1; j < SHARES; j++) begin
        sumD[i] = sumD[i] ^ crossLoQ[k];
        sumD[j] = sumD[j] ^ crossHiQ[k];
        k = k + 1;
      end
    end
    sumFlat = '0;
    for (int unsigned i = 0; i < SHARES; i++) sumFlat[i*N +: N] = sumD[i];
  end

  if (OUT_REG) begin : gOutReg
    logic [DataW-1:0] qQ;
    logic             v2Q;

    assign advance1       = ~v2Q | bus.OutReadyxS;
    assign bus.QxD        = qQ;
    assign bus.OutValidxS = v2Q;

    // Stage 2: output register, loads whenever stage 1 may advance.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
      if (!RstxBI) begin
        qQ  <= '0;
        v2Q <= 1'b0;
      end else if (FlushxSI) begin
        qQ  <= '0;
        v2Q <= 1'b0;
      end else if (v1Q && advance1) begin
        qQ  <= sumFlat;
        v2Q <= 1'b1;
      end else if (bus.OutReadyxS) begin
        v2Q <= 1'b0;
      end
    end
  end else begin : gOutComb
    assign advance1       = bus.OutReadyxS;
    assign bus.QxD        = sumFlat;
    assign bus.OutValidxS = v1Q;
  end

endmodule

// File: tb/tb_dom_shared_mul_gf2n_pipe.sv
// Randomised bench for the DOM GF(2^N) multiplier: a GF(2^4)/2-share
// instance with output register and a GF(2^8)/3-share instance without.
module tb_dom_shared_mul_gf2n_pipe;

  logic clk;
  logic rst_n;
  logic flushA;
  logic flushB;

  int checks;
  int errors;

  dom_shared_mul_gf2n_pipe_if #(.N(4), .SHARES(2)) ifA ();
  dom_shared_mul_gf2n_pipe_if #(.N(8), .SHARES(3)) ifB ();

  dom_shared_mul_gf2n_pipe #(.N(4), .POLY(5'h13), .SHARES(2), .OUT_REG(1'b1)) dutA (
    .ClkxCI(clk), .RstxBI(rst_n), .FlushxSI(flushA), .bus(ifA)
  );

  dom_shared_mul_gf2n_pipe #(.N(8), .POLY(9'h11B), .SHARES(3), .OUT_REG(1'b0)) dutB (
    .ClkxCI(clk), .RstxBI(rst_n), .FlushxSI(flushB), .bus(ifB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  // Reference model: polynomial long multiplication then long division.
  function automatic int unsigned refMul(input int unsigned a, input int unsigned b,
                                         input int unsigned n, input int unsigned poly);
    int unsigned p;
    p = 0;
    for (int unsigned i = 0; i < n; i++)
      if (((b >> i) & 1) != 0) p = p ^ (a << i);
    for (int unsigned d = 2*n - 2; d >= n; d--)
      if (((p >> d) & 1) != 0) p = p ^ (poly << (d - n));
    return p;
  endfunction

  function automatic int unsigned xorA(input logic [7:0] v);
    return 32'(v[3:0] ^ v[7:4]);
  endfunction

  function automatic int unsigned xorB(input logic [23:0] v);
    return 32'(v[7:0] ^ v[15:8] ^ v[23:16]);
  endfunction

  // Scoreboards: expected unshared products, plus register age for instance A.
  int unsigned qA[$];
  int unsigned ageA[$];
  int unsigned qB[$];
  int unsigned curA, curB;
  bit lastAccA, lastAccB;
  bit obsAckA, obsReadyA, obsValidA;
  logic [7:0]  obsQA;
  logic [23:0] obsQB;
  int popsA, popsB;

  task automatic setOpA(input int unsigned x, input int unsigned y);
    int unsigned x0, y0;
    x0 = $urandom_range(0, 15);
    y0 = $urandom_range(0, 15);
    ifA.XxD = {4'(x ^ x0), 4'(x0)};
    ifA.YxD = {4'(y ^ y0), 4'(y0)};
    ifA.ZxD = 4'($urandom);
    curA = refMul(x, y, 4, 32'h13);
  endtask

  task automatic setOpB(input int unsigned x, input int unsigned y);
    int unsigned x0, x1, y0, y1;
    x0 = $urandom_range(0, 255); x1 = $urandom_range(0, 255);
    y0 = $urandom_range(0, 255); y1 = $urandom_range(0, 255);
    ifB.XxD = {8'(x ^ x0 ^ x1), 8'(x1), 8'(x0)};
    ifB.YxD = {8'(y ^ y0 ^ y1), 8'(y1), 8'(y0)};
    ifB.ZxD = 24'($urandom);
    curB = refMul(x, y, 8, 32'h11B);
  endtask

  // One clock cycle on instance A: drive, check at negedge, advance model.
  task automatic stepA(input bit inV, input bit rndV, input bit outR, input bit fl);
    bit expValid, expReady, expAcc;
    ifA.InValidxS  = inV;
    ifA.RndValidxS = rndV;
    ifA.OutReadyxS = outR;
    flushA         = fl;
    @(negedge clk);
    expValid = (qA.size() > 0) && (ageA[0] >= 2);
    expReady = !fl && ((qA.size() < 2) || outR);
    expAcc   = inV && rndV && expReady;
    checks++;
    if (ifA.OutValidxS !== expValid) begin
      errors++;
      $display("FAIL A_out_valid got %b want %b at %0t", ifA.OutValidxS, expValid, $time);
    end
    checks++;
    if (ifA.InReadyxS !== expReady) begin
      errors++;
      $display("FAIL A_in_ready got %b want %b at %0t", ifA.InReadyxS, expReady, $time);
    end
    checks++;
    if (ifA.RndAckxS !== expAcc) begin
      errors++;
      $display("FAIL A_rnd_ack got %b want %b at %0t", ifA.RndAckxS, expAcc, $time);
    end
    if (expValid && outR) begin
      checks++;
      if (xorA(ifA.QxD) !== qA[0]) begin
        errors++;
        $display("FAIL A_product got %h want %h at %0t", xorA(ifA.QxD), qA[0], $time);
      end
      popsA++;
    end
    obsQA     = ifA.QxD;
    obsAckA   = ifA.RndAckxS;
    obsReadyA = ifA.InReadyxS;
    obsValidA = ifA.OutValidxS;
    lastAccA  = expAcc;
    @(posedge clk);
    #1;
    if (fl) begin
      qA.delete();
      ageA.delete();
    end else begin
      foreach (ageA[i]) ageA[i]++;
      if (expValid && outR) begin
        void'(qA.pop_front());
        void'(ageA.pop_front());
      end
      if (expAcc) begin
        qA.push_back(curA);
        ageA.push_back(1);
      end
    end
  endtask

  // One clock cycle on instance B (single stage, latency 1).
  task automatic stepB(input bit inV, input bit rndV, input bit outR);
    bit expValid, expReady, expAcc;
    ifB.InValidxS  = inV;
    ifB.RndValidxS = rndV;
    ifB.OutReadyxS = outR;
    flushB         = 1'b0;
    @(negedge clk);
    expValid = qB.size() > 0;
    expReady = (qB.size() == 0) || outR;
    expAcc   = inV && rndV && expReady;
    checks++;
    if (ifB.OutValidxS !== expValid) begin
      errors++;
      $display("FAIL B_out_valid got %b want %b at %0t", ifB.OutValidxS, expValid, $time);
    end
    checks++;
    if (ifB.InReadyxS !== expReady) begin
      errors++;
      $display("FAIL B_in_ready got %b want %b at %0t", ifB.InReadyxS, expReady, $time);
    end
    checks++;
    if (ifB.RndAckxS !== expAcc) begin
      errors++;
      $display("FAIL B_rnd_ack got %b want %b at %0t", ifB.RndAckxS, expAcc, $time);
    end
    if (expValid && outR) begin
      checks++;
      if (xorB(ifB.QxD) !== qB[0]) begin
        errors++;
        $display("FAIL B_product got %h want %h at %0t", xorB(ifB.QxD), qB[0], $time);
      end
      popsB++;
    end
    obsQB    = ifB.QxD;
    lastAccB = expAcc;
    @(posedge clk);
    #1;
    if (expValid && outR) void'(qB.pop_front());
    if (expAcc) qB.push_back(curB);
  endtask

  task automatic checkResetOutputs(input string tag);
    checks++;
    if (ifA.QxD !== 8'h00 || ifA.OutValidxS !== 1'b0 || ifA.RndAckxS !== 1'b0) begin
      errors++;
      $display("FAIL %s_A got q=%h v=%b ack=%b want q=00 v=0 ack=0", tag,
               ifA.QxD, ifA.OutValidxS, ifA.RndAckxS);
    end
    checks++;
    if (ifB.QxD !== 24'h0 || ifB.OutValidxS !== 1'b0 || ifB.RndAckxS !== 1'b0) begin
      errors++;
      $display("FAIL %s_B got q=%h v=%b ack=%b want q=0 v=0 ack=0", tag,
               ifB.QxD, ifB.OutValidxS, ifB.RndAckxS);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flushA = 1'b0; flushB = 1'b0;
    setOpA(1, 1);
    setOpB(1, 1);
    ifA.InValidxS = 1'b1; ifA.RndValidxS = 1'b1; ifA.OutReadyxS = 1'b1;
    ifB.InValidxS = 1'b1; ifB.RndValidxS = 1'b1; ifB.OutReadyxS = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    ifA.InValidxS = 1'b0;
    ifB.InValidxS = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_answer();
    ifA.XxD = 8'h9A;
    ifA.YxD = 8'h25;
    ifA.ZxD = 4'hF;
    curA = refMul(3, 7, 4, 32'h13);
    stepA(1'b1, 1'b1, 1'b1, 1'b0);
    stepA(1'b0, 1'b0, 1'b1, 1'b0);
    stepA(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (obsValidA !== 1'b1 || xorA(obsQA) !== 32'h9) begin
      errors++;
      $display("FAIL known_answer got v=%b q=%h want v=1 q=9", obsValidA, xorA(obsQA));
    end
    stepA(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int startPops;
    startPops = popsA;
    for (int i = 0; i < 16; i++) begin
      setOpA($urandom_range(0, 15), $urandom_range(0, 15));
      stepA(1'b1, 1'b1, 1'b1, 1'b0);
    end
    repeat (3) stepA(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (popsA - startPops != 16) begin
      errors++;
      $display("FAIL back_to_back_count got %0d want 16", popsA - startPops);
    end
  endtask

  task automatic test_stall();
    int startPops, accepts;
    logic [7:0] heldQ;
    startPops = popsA;
    accepts = 0;
    lastAccA = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (lastAccA) setOpA($urandom_range(0, 15), $urandom_range(0, 15));
      stepA(1'b1, 1'b1, 1'b0, 1'b0);
      if (lastAccA) accepts++;
      if (c == 2) heldQ = obsQA;
      if (c > 2) begin
        checks++;
        if (obsQA !== heldQ || obsReadyA !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold got q=%h rdy=%b want q=%h rdy=0", obsQA, obsReadyA, heldQ);
        end
      end
    end
    checks++;
    if (accepts != 2) begin
      errors++;
      $display("FAIL stall_accepts got %0d want 2", accepts);
    end
    for (int c = 0; c < 8 && !lastAccA; c++) stepA(1'b1, 1'b1, 1'b1, 1'b0);
    repeat (4) stepA(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (popsA - startPops != 3) begin
      errors++;
      $display("FAIL stall_drain got %0d want 3", popsA - startPops);
    end
  endtask

  task automatic test_rnd_handshake();
    int acks;
    acks = 0;
    setOpA($urandom_range(0, 15), $urandom_range(0, 15));
    for (int c = 0; c < 3; c++) begin
      stepA(1'b1, 1'b0, 1'b1, 1'b0);
      if (obsAckA) acks++;
    end
    stepA(1'b1, 1'b1, 1'b1, 1'b0);
    if (obsAckA) acks++;
    stepA(1'b0, 1'b1, 1'b1, 1'b0);
    if (obsAckA) acks++;
    checks++;
    if (acks != 1) begin
      errors++;
      $display("FAIL rnd_ack_pulses got %0d want 1", acks);
    end
    repeat (2) stepA(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_flush_and_reset();
    int startPops;
    startPops = popsA;
    setOpA($urandom_range(0, 15), $urandom_range(0, 15));
    stepA(1'b1, 1'b1, 1'b0, 1'b0);
    setOpA($urandom_range(0, 15), $urandom_range(0, 15));
    stepA(1'b1, 1'b1, 1'b0, 1'b0);
    stepA(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (3) stepA(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (popsA != startPops) begin
      errors++;
      $display("FAIL flush_discard got %0d results want 0", popsA - startPops);
    end
    setOpA($urandom_range(0, 15), $urandom_range(0, 15));
    stepA(1'b1, 1'b1, 1'b0, 1'b0);
    setOpA($urandom_range(0, 15), $urandom_range(0, 15));
    stepA(1'b1, 1'b1, 1'b0, 1'b0);
    stepA(1'b1, 1'b1, 1'b0, 1'b0);
    setOpB(8'h12, 8'h34);
    ifB.InValidxS = 1'b1; ifB.RndValidxS = 1'b1; ifB.OutReadyxS = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkResetOutputs("async_reset");
    @(negedge clk);
    checkResetOutputs("reset_hold");
    ifA.InValidxS = 1'b0;
    ifB.InValidxS = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    qA.delete(); ageA.delete(); qB.delete();
    test_known_answer();
  endtask

  task automatic test_gf256();
    int startPops;
    startPops = popsB;
    setOpB(8'h57, 8'h83);
    stepB(1'b1, 1'b1, 1'b1);
    setOpB($urandom_range(0, 255), $urandom_range(0, 255));
    stepB(1'b1, 1'b1, 1'b1);
    checks++;
    if (xorB(obsQB) !== 32'hC1) begin
      errors++;
      $display("FAIL gf256_57x83 got %h want c1", xorB(obsQB));
    end
    for (int c = 0; c < 30; c++) begin
      if (lastAccB) setOpB($urandom_range(0, 255), $urandom_range(0, 255));
      stepB(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0));
    end
    repeat (2) stepB(1'b0, 1'b0, 1'b1);
    checks++;
    if (qB.size() != 0 || popsB - startPops < 3) begin
      errors++;
      $display("FAIL gf256_drain got left=%0d done=%0d want left=0 done>=3",
               qB.size(), popsB - startPops);
    end
  endtask

  task automatic test_random_flow();
    lastAccA = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (lastAccA) setOpA($urandom_range(0, 15), $urandom_range(0, 15));
      stepA(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    repeat (4) stepA(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    popsA = 0;
    popsB = 0;
    lastAccA = 1'b0;
    lastAccB = 1'b1;
    test_reset();
    test_known_answer();
    test_back_to_back();
    test_stall();
    test_rnd_handshake();
    test_gf256();
    test_random_flow();
    test_flush_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
